// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronises and debounces a raw pad, then derives
// press/release pulses and a press pulse train with auto-repeat while held.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       BTN_RAW,
  output logic       BTN,
  output logic       PRESS,
  output logic       RELEASE,
  output logic       REPEAT,
  output logic [1:0] o_dbg_state
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [DW-1:0]          r_dcnt;
  logic                   r_btn;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;
  logic                   w_accept;
  logic                   w_press;
  logic                   w_release;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [RW-1:0]          r_rcnt;
  logic [RW-1:0]          w_rcnt_next;
  logic                   w_repeat_next;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], BTN_RAW};
    end
  end

  // A level is accepted on the sample that completes DEBOUNCE_CYCLES disagreements in a row.
  assign w_accept  = (w_s != r_btn) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_accept && w_s;
  assign w_release = w_accept && !w_s;

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dcnt    <= '0;
      r_btn     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_press;
      r_release <= w_release;
      if (w_s == r_btn) begin
        r_dcnt <= '0;
      end else if (w_accept) begin
        r_btn  <= w_s;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rcnt   <= w_rcnt_next;
      r_repeat <= w_repeat_next;
    end
  end

  // The FSM reacts to the unregistered edge events so REPEAT lines up with PRESS.
  always_comb begin
    w_state_next  = r_state;
    w_rcnt_next   = r_rcnt;
    w_repeat_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_repeat_next = 1'b1;
          w_state_next  = ST_DELAY;
          w_rcnt_next   = '0;
        end
      end
      ST_DELAY: begin
        if (w_release) begin
          w_state_next = ST_IDLE;
          w_rcnt_next  = '0;
        end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
          w_repeat_next = 1'b1;
          w_state_next  = ST_RPT;
          w_rcnt_next   = '0;
        end else begin
          w_rcnt_next = r_rcnt + RW'(1);
        end
      end
      ST_RPT: begin
        if (w_release) begin
          w_state_next = ST_IDLE;
          w_rcnt_next  = '0;
        end else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
          w_repeat_next = 1'b1;
          w_rcnt_next   = '0;
        end else begin
          w_rcnt_next = r_rcnt + RW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_rcnt_next  = '0;
      end
    endcase
  end

  assign BTN         = r_btn;
  assign PRESS       = r_press;
  assign RELEASE     = r_release;
  assign REPEAT      = r_repeat;
  assign o_dbg_state = r_state;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Conditions the raw push-button input (BTNU on the Nexys A7) before it reaches the game core's BTN input, in the 25 MHz pixel-clock domain. It synchronises the asynchronous pad and debounces it into a stable level. It also emits single-cycle press and release pulses, plus a press pulse train with auto-repeat. The board top instantiates it between the pad and topEntity.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2)
DEBOUNCE_CYCLES, 250000, consecutive cycles a new level must persist before acceptance (10 ms @ 25 MHz; >=1)
REPEAT_DELAY, 12500000, cycles from PRESS to first auto-repeat pulse (500 ms; >=1)
REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (100 ms; >=1)

Ports:
CLK_25MHZ  in  1  pixel clock, all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset (assert async, deassert sync'd externally by MMCM lock logic)
BTN_RAW  in  1  raw pad, asynchronous, bouncy
BTN  out  1  debounced level
PRESS  out  1  one-cycle pulse on BTN 0->1
RELEASE  out  1  one-cycle pulse on BTN 1->0
REPEAT  out  1  one-cycle pulse: on press, then auto-repeat while held

Behaviour:
- Reset (RESET_N=0, async): synchroniser flops, stable level, both counters = 0; FSM = IDLE; BTN, PRESS, RELEASE, REPEAT = 0.
- Synchroniser: BTN_RAW through SYNC_STAGES flops; s = last stage output. No logic between stages.
- Debounce, per cycle:
  - s == BTN: dcnt <= 0.
  - s != BTN and dcnt == DEBOUNCE_CYCLES-1: BTN <= s, dcnt <= 0.
  - Otherwise: dcnt++.
  - BTN therefore changes on the edge where s has differed for DEBOUNCE_CYCLES consecutive samples. Any single-cycle agreement restarts the count.
- Latency: raw edge (held clean) to BTN change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- dcnt width = clog2(DEBOUNCE_CYCLES), min 1. The counter never wraps.
- PRESS/RELEASE are registered and asserted in the same cycle BTN first shows its new value, for exactly 1 cycle. They are mutually exclusive.
- Repeat FSM, states IDLE, DELAY, RPT; rcnt width = clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - IDLE: on PRESS -> REPEAT=1 that cycle, go to DELAY, rcnt <= 0.
  - DELAY: rcnt++. When rcnt == REPEAT_DELAY-1: REPEAT=1, go to RPT, rcnt <= 0. First repeat is exactly REPEAT_DELAY cycles after PRESS.
  - RPT: rcnt++. When rcnt == REPEAT_PERIOD-1: REPEAT=1, rcnt <= 0.
  - RELEASE in DELAY or RPT: go to IDLE, rcnt <= 0. RELEASE wins over a simultaneous counter expiry, so no REPEAT pulse that cycle.
- Simultaneous events: PRESS and RELEASE cannot coincide. A re-press after release always re-enters through IDLE with a fresh REPEAT pulse.
- Reset mid-operation: all state clears immediately. A button still held at reset release is re-accepted as a new press after SYNC_STAGES + DEBOUNCE_CYCLES cycles, since BTN restarts at 0.
- Outputs are glitch-free registered signals. No combinational path from BTN_RAW to any output.

Test Plan:
(Bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; cycle 0 = first edge sampling BTN_RAW=1.)
- Clean press: BTN_RAW 0->1 held -> BTN=1, PRESS=1, REPEAT=1 at cycle 6 only; PRESS low at cycle 7.
- Bounce rejection: BTN_RAW pulses 1 for 3 cycles, then 0, repeated 5 times -> BTN, PRESS, REPEAT stay 0 throughout.
- Auto-repeat: hold BTN_RAW=1 for 40 cycles -> REPEAT pulses at cycles 6, 16, 19, 22, 25, ... (period 3). PRESS only at 6.
- Release: drop BTN_RAW at cycle 20 -> RELEASE=1 and BTN=0 at cycle 26. No REPEAT at 26 or later, even though cycle 25 fired and the period would hit 28. FSM in IDLE.
- Release at expiry: release timed so RELEASE lands on the cycle DELAY would expire -> REPEAT stays 0 that cycle.
- Reset mid-hold: assert RESET_N=0 at cycle 18 with button held -> all outputs 0 immediately (async). Deassert at 21 -> PRESS/REPEAT re-fire 6 cycles after the first post-reset sampling edge.
